// File: rtl/voxel_pkg.sv
// Shared constants and types for the 32x32x32 voxel grid.
// Linear addresses are laid out as {iz, iy, ix}.
package voxel_pkg;

  localparam int COORD_W  = 5;
  localparam int GRID_DIM = 2 ** COORD_W;
  localparam int ADDR_W   = 3 * COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } voxel_coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } walker_state_t;

endpackage

// File: rtl/voxel_addr_decode.sv
// Combinational linear-address to (x, y, z) coordinate split.
// Pure bit-slicing, so it adds no logic depth beyond wiring.
module voxel_addr_decode
  import voxel_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output voxel_coord_t      coord
);

  assign coord.x = addr[COORD_W-1:0];
  assign coord.y = addr[2*COORD_W-1:COORD_W];
  assign coord.z = addr[3*COORD_W-1:2*COORD_W];

endmodule

// File: rtl/voxel_addr_walker.sv
// Walks consecutive linear voxel addresses (with wrap) for a commanded count
// and streams each address with its decoded coordinates.
module voxel_addr_walker
  import voxel_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_start_addr,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [COORD_W-1:0]   out_ix,
  output logic [COORD_W-1:0]   out_iy,
  output logic [COORD_W-1:0]   out_iz,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output walker_state_t        dbg_state
);

  // Handshake: a command moves on cmd_valid & cmd_ready, a beat moves on
  // out_valid & out_ready. A producer holds its payload stable until it moves.

  walker_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                done_q, done_d;
  logic                last_beat;
  logic                xfer;
  voxel_coord_t        coord;

  assign last_beat = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign xfer      = (state_q == RUN) && out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_count != '0) begin
            addr_d  = cmd_start_addr;
            rem_d   = cmd_count;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            done_d  = !abort;
          end
        end
        // A cancelled sweep never reports completion.
        if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  voxel_addr_decode u_decode (
    .addr  (addr_q),
    .coord (coord)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign out_addr  = addr_q;
  assign out_ix    = coord.x;
  assign out_iy    = coord.y;
  assign out_iz    = coord.z;
  assign out_last  = last_beat;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/voxel_addr_walker.md
# voxel_addr_walker

Sequential address/coordinate stream generator for the 32x32x32 voxel grid. Accepts a command (start address, voxel count), walks consecutive linear addresses with wrap-around, and emits each address alongside its decoded (ix, iy, iz) coordinates over a valid/ready stream. It is the inverse-direction companion to the grid's coordinate-to-address mapping: it turns linear addresses `{iz, iy, ix}` back into coordinates for grid initialisation, scrub and readback sweeps.

## Interface
- COORD_W, 5, bits per coordinate axis (grid edge = 2**COORD_W)
- ADDR_W, 3*COORD_W (15), linear address width; derived, not overridden
- CNT_W, 16, command count width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  walker idle and can accept a command
- cmd_start_addr  in  ADDR_W  first linear address of the sweep
- cmd_count  in  CNT_W  number of voxels to emit (0 = no-op)
- abort  in  1  synchronous sweep cancel
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_addr  out  ADDR_W  current linear address
- out_ix / out_iy / out_iz  out  COORD_W each  addr[4:0] / addr[9:5] / addr[14:10]
- out_last  out  1  current beat is final beat of the sweep
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse on normal sweep completion

## Operation
- States: IDLE, RUN. cmd_ready = (state == IDLE); busy = (state == RUN); out_valid = (state == RUN).
- IDLE, cmd_valid & cmd_ready, cmd_count > 0: load addr_q = cmd_start_addr, rem_q = cmd_count; go RUN.
- IDLE, accepted cmd with cmd_count == 0: stay IDLE; done pulses next cycle; no beats emitted.
- RUN: out_addr = addr_q; coordinates are pure bit-slices of addr_q; out_last = (rem_q == 1).
- Beat transfer (out_valid & out_ready): addr_q <= addr_q + 1 modulo 2**ADDR_W (32767 -> 0); rem_q <= rem_q - 1. If out_last, go IDLE and pulse done next cycle.
- Stall (out_valid & !out_ready): all out_* hold stable.
- Counts > 32768 are legal; addresses wrap and repeat.
- abort in RUN: go IDLE next cycle, no done pulse. If abort coincides with a transfer, that beat counts as delivered; nothing further is emitted. abort in IDLE is ignored and does not block a same-cycle command.
- cmd_* ignored while RUN (cmd_ready = 0).

## Timing
- Reset values: state IDLE, addr_q 0, rem_q 0, out_valid 0, out_addr/ix/iy/iz 0, out_last 0, busy 0, done 0, cmd_ready 1.
- Reset mid-sweep: outputs return immediately to reset values; no done pulse.
- Command accepted in cycle N -> first beat valid in cycle N+1.
- Throughput: one beat per cycle with out_ready held high; an N-beat sweep occupies cycles N+1..N+count.
- Last beat transferred in cycle M -> done = 1 and cmd_ready = 1 in cycle M+1. Next command can be accepted in M+1; its first beat appears in M+2.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Structure
- Shared package voxel_pkg: COORD_W, GRID_DIM, ADDR_W constants; voxel_coord_t packed struct {z, y, x}; walker_state_t enum {IDLE, RUN}.
- Sub-module voxel_addr_decode: combinational ADDR_W -> voxel_coord_t slice. Reusable elsewhere; instantiated once here on addr_q.

## Test plan
- Basic sweep: start 0x0000, count 4, out_ready = 1 -> addrs 0,1,2,3 in consecutive cycles; addr 3 gives ix=3, iy=0, iz=0; out_last on beat 4; done one cycle later.
- Decode/wrap: start 0x7FFE, count 3 -> addrs 0x7FFE, 0x7FFF, 0x0000; 0x7FFF decodes to (31,31,31); 0x0000 to (0,0,0).
- Back-pressure: start 0x03E0, count 2, out_ready low for 3 cycles on beat 1 -> addr 0x03E0 (ix=0, iy=31, iz=0) held stable; 2 beats total, no duplicates or drops.
- Zero count: cmd_count = 0 -> out_valid never asserts; done pulses the cycle after accept; cmd_ready stays 1.
- Abort: start 0x0400, count 10, abort with the 3rd beat's transfer -> exactly 3 beats (0x0400..0x0402); IDLE next cycle; no done pulse.
- Async reset mid-sweep: assert rst_n = 0 between clock edges during beat 5 -> out_valid, busy, out_addr drop to 0 immediately; after release, cmd_ready = 1 and a new sweep runs correctly.
